alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 51 +++++
 rtl/alu_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Request, response and shared-ALU signal bundle for alu_arbiter.
// slave is the arbiter side; master is the requester/ALU side.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req0_ctrl;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req1_ctrl;

    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;

    logic        busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        input  alu_result, alu_zero,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid,
        output rsp_result, rsp_zero, rsp_err,
        output alu_a, alu_b, alu_ctrl,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        output alu_result, alu_zero,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid,
        input  rsp_result, rsp_zero, rsp_err,
        input  alu_a, alu_b, alu_ctrl,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// Optional ALU_ARB_ILLEGAL_CHK_EN: unsupported op codes answer early with rsp_err.
module alu_arbiter (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_ctrl;
    logic        op_id;
    logic        last;

    logic [31:0] res_q;
    logic        zero_q;

    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic [31:0] acc_a;
    logic [31:0] acc_b;
    logic [3:0]  acc_ctrl;
    logic        bad;

    // last == 1 means requester 1 was served most recently, so 0 wins a tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE && !rst) begin
            unique case (1'b1)
                bus.req0_valid && !bus.req1_valid: gnt0 = 1'b1;
                bus.req1_valid && !bus.req0_valid: gnt1 = 1'b1;
                bus.req0_valid && bus.req1_valid: begin
                    gnt0 = last;
                    gnt1 = !last;
                end
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end
    end

    assign accept   = gnt0 | gnt1;
    assign acc_a    = gnt1 ? bus.req1_a    : bus.req0_a;
    assign acc_b    = gnt1 ? bus.req1_b    : bus.req0_b;
    assign acc_ctrl = gnt1 ? bus.req1_ctrl : bus.req0_ctrl;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    logic err_q;

    function automatic logic supported(input logic [3:0] c);
        return c inside {4'b0000, 4'b0001, 4'b0010,
                         4'b0110, 4'b0111, 4'b1100};
    endfunction

    assign bad = !supported(acc_ctrl);
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = bad ? RESP : EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            op_ctrl <= '0;
            op_id   <= 1'b0;
            last    <= 1'b1;
        end else begin
            if (accept) begin
                op_a    <= acc_a;
                op_b    <= acc_b;
                op_ctrl <= acc_ctrl;
                op_id   <= gnt1;
            end
            if (state == RESP) begin
                last <= op_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= '0;
            zero_q <= 1'b0;
        end else if (state == EXEC) begin
            res_q  <= bus.alu_result;
            zero_q <= bus.alu_zero;
        end else if (accept && bad) begin
            res_q  <= '0;
            zero_q <= 1'b0;
        end
    end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == EXEC) begin
            err_q <= 1'b0;
        end else if (accept && bad) begin
            err_q <= 1'b1;
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // a reset landing on the response cycle suppresses the pulse
    assign bus.rsp0_valid = (state == RESP) && !op_id && !rst;
    assign bus.rsp1_valid = (state == RESP) &&  op_id && !rst;

    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;

    assign bus.alu_a    = op_a;
    assign bus.alu_b    = op_b;
    assign bus.alu_ctrl = op_ctrl;

    assign bus.busy = (state != IDLE);
endmodule
